byte_stream_summer: RTL and testbench

- Sequential, streaming counterpart of the parallel 16-operand byte adder tree.
- Accepts 8-bit operands one per valid/ready handshake and accumulates them into a 32-bit sum.
- Presents the finished sum, byte count and overflow flag on an output valid/ready handshake.
- Sits between a byte-stream source (FIFO or bus reader) and any consumer of the registered 32-bit total.

---
 rtl/sum_pkg.sv | 16 +
 rtl/byte_stream_summer_add.sv | 17 +
 rtl/byte_stream_summer.sv | 121 ++++++++++++
 tb/tb_byte_stream_summer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the byte stream summer.
// Holds the controller state type and the default parameter values
// used by byte_stream_summer and its testbench.
package sum_pkg;

  // ACC collects operands, HOLD presents a finished frame result
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DATA_W_D = 8;
  localparam int SUM_W_D  = 32;
  localparam int COUNT_D  = 16;

endpackage

// File: rtl/byte_stream_summer_add.sv
// ADD: plain unsigned combinational adder.
// The top widens its accumulator by one bit before using this block,
// so the MSB of sum is the carry out of the real accumulator.
// Ports:
//   a, b : WIDTH-bit unsigned operands
//   sum  : WIDTH-bit result, a + b modulo 2^WIDTH
module ADD #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/byte_stream_summer.sv
// byte_stream_summer: streaming accumulator for framed byte operands.
// Bytes arrive one per valid/ready handshake and are summed into a
// SUM_W-bit accumulator. A frame closes on in_last or on the COUNT-th
// accepted byte. The registered result is then held on an output
// valid/ready handshake.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_data   : operand byte
//   in_valid  : in_data valid
//   in_last   : this byte closes the frame early
//   in_ready  : block can accept an operand
//   out_sum   : frame sum (modulo 2^SUM_W)
//   out_len   : operands in the frame (1..COUNT)
//   out_ovf   : a carry out of SUM_W happened during the frame
//   out_valid : out_sum/out_len/out_ovf valid
//   out_ready : consumer accepts the result
module byte_stream_summer
  import sum_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int SUM_W  = SUM_W_D,
  parameter int COUNT  = COUNT_D,
  parameter int CNT_W  = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_len,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] COUNT_LIM = CNT_W'(COUNT);

  state_t           state;
  state_t           state_next;
  logic [SUM_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [SUM_W:0]   add_a;
  logic [SUM_W:0]   add_b;
  logic [SUM_W:0]   add_y;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             close;
  logic             carry;

  // in_ready is gated by rst so upstream sees "not ready" during reset
  assign in_ready = (state == ACC) && rst;
  assign accept   = in_valid && in_ready;
  assign cnt_next = cnt + CNT_W'(1);
  assign close    = accept && (in_last || (cnt_next == COUNT_LIM));

  // One extra adder bit turns the adder's MSB into the overflow carry
  assign add_a = {1'b0, acc};
  assign add_b = {{(SUM_W + 1 - DATA_W){1'b0}}, in_data};
  assign carry = add_y[SUM_W];

  ADD #(
    .WIDTH(SUM_W + 1)
  ) u_add (
    .a  (add_a),
    .b  (add_b),
    .sum(add_y)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ACC:     if (close) state_next = HOLD;
      HOLD:    if (out_valid && out_ready) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Accept only happens in ACC and the output handshake only in HOLD,
  // so the two branches never compete.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (close) begin
        out_sum   <= add_y[SUM_W-1:0];
        out_len   <= cnt_next;
        out_ovf   <= ovf | carry;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= add_y[SUM_W-1:0];
        cnt <= cnt_next;
        ovf <= ovf | carry;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_stream_summer.sv
// Testbench for byte_stream_summer.
// Drives directed byte frames into a default build (32-bit sum, COUNT=16)
// and a SUM_W=8 build, comparing results against hand-computed values.
module tb_byte_stream_summer;

  logic        clk;
  logic        rst;

  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_sum;
  logic [4:0]  out_len;
  logic        out_ovf;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  s8_in_data;
  logic        s8_in_valid;
  logic        s8_in_last;
  logic        s8_in_ready;
  logic [7:0]  s8_out_sum;
  logic [4:0]  s8_out_len;
  logic        s8_out_ovf;
  logic        s8_out_valid;
  logic        s8_out_ready;

  int checks;
  int failures;
  int pulses;
  int stalls;

  byte_stream_summer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_len  (out_len),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  byte_stream_summer #(
    .SUM_W(8)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s8_in_data),
    .in_valid (s8_in_valid),
    .in_last  (s8_in_last),
    .in_ready (s8_in_ready),
    .out_sum  (s8_out_sum),
    .out_len  (s8_out_len),
    .out_ovf  (s8_out_ovf),
    .out_valid(s8_out_valid),
    .out_ready(s8_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts output handshakes on the default build
  always @(posedge clk) begin
    if (rst && out_valid && out_ready) pulses <= pulses + 1;
  end

  // Sends n bytes base, base+step, ... starting and ending at a negedge.
  // Waits for in_ready with a bounded loop; cycles spent waiting go to stalls.
  task automatic send_bytes(input int n, input logic [7:0] base,
                            input logic [7:0] step, input bit use_last);
    for (int i = 0; i < n; i++) begin
      int guard;
      in_data  = base + 8'(i) * step;
      in_last  = use_last && (i == n - 1);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
        stalls++;
      end
      checks++;
      if (guard >= 50) begin
        failures++;
        $display("[TB] FAIL send_timeout byte %0d: in_ready stayed %b, required 1", i, in_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_ovf} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags got valid/ready/ovf=%b required 000", {out_valid, in_ready, out_ovf});
    end
    checks++;
    if (out_sum !== 32'd0 || out_len !== 5'd0) begin
      failures++;
      $display("[TB] FAIL reset_data got sum=%0d len=%0d required 0 0", out_sum, out_len);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset got %b required 1", in_ready);
    end
  endtask

  task automatic test_full_frame;
    pulses = 0;
    stalls = 0;
    out_ready = 1'b1;
    send_bytes(16, 8'd1, 8'd1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_valid got valid=%b ready=%b required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_sum !== 32'd136 || out_len !== 5'd16 || out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_result got sum=%0d len=%0d ovf=%b required 136 16 0", out_sum, out_len, out_ovf);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL full_release got valid=%b ready=%b required 0 1", out_valid, in_ready);
    end
    checks++;
    if (pulses !== 1 || stalls !== 0) begin
      failures++;
      $display("[TB] FAIL full_pulses got pulses=%0d stalls=%0d required 1 0", pulses, stalls);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    stalls = 0;
    send_bytes(16, 8'hFF, 8'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0000_0FF0 || out_len !== 5'd16) begin
      failures++;
      $display("[TB] FAIL ff_frame1 got valid=%b sum=%0d len=%0d required 1 4080 16", out_valid, out_sum, out_len);
    end
    send_bytes(16, 8'hFF, 8'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h0000_0FF0 || out_len !== 5'd16) begin
      failures++;
      $display("[TB] FAIL ff_frame2 got valid=%b sum=%0d len=%0d required 1 4080 16", out_valid, out_sum, out_len);
    end
    checks++;
    if (stalls !== 1) begin
      failures++;
      $display("[TB] FAIL ff_bubble got stalls=%0d required 1", stalls);
    end
    @(negedge clk);
  endtask

  task automatic test_early_last;
    out_ready = 1'b1;
    send_bytes(3, 8'd10, 8'd10, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd60 || out_len !== 5'd3) begin
      failures++;
      $display("[TB] FAIL last3 got valid=%b sum=%0d len=%0d required 1 60 3", out_valid, out_sum, out_len);
    end
    @(negedge clk);
    send_bytes(1, 8'h07, 8'd0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd7 || out_len !== 5'd1) begin
      failures++;
      $display("[TB] FAIL last1 got valid=%b sum=%0d len=%0d required 1 7 1", out_valid, out_sum, out_len);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_bytes(3, 8'd1, 8'd1, 1'b1);
    in_data  = 8'h55;
    in_last  = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 32'd6 || out_len !== 5'd3) begin
        failures++;
        $display("[TB] FAIL hold_stable cycle %0d got ready=%b valid=%b sum=%0d len=%0d required 0 1 6 3",
                 i, in_ready, out_valid, out_sum, out_len);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_release got ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
    @(negedge clk);
    in_data = 8'h01;
    in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'h56 || out_len !== 5'd2) begin
      failures++;
      $display("[TB] FAIL hold_nodrop got valid=%b sum=%0h len=%0d required 1 56 2", out_valid, out_sum, out_len);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    out_ready = 1'b1;
    send_bytes(5, 8'd9, 8'd1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midreset cycle %0d got valid=%b ready=%b required 0 0", i, out_valid, in_ready);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    send_bytes(16, 8'd1, 8'd1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_sum !== 32'd136 || out_len !== 5'd16) begin
      failures++;
      $display("[TB] FAIL midreset_next got valid=%b sum=%0d len=%0d required 1 136 16", out_valid, out_sum, out_len);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    s8_out_ready = 1'b1;
    s8_in_valid  = 1'b1;
    s8_in_data   = 8'h80;
    s8_in_last   = 1'b0;
    checks++;
    if (s8_in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_ready got %b required 1", s8_in_ready);
    end
    @(negedge clk);
    s8_in_last = 1'b1;
    @(negedge clk);
    s8_in_valid = 1'b0;
    s8_in_last  = 1'b0;
    checks++;
    if (s8_out_valid !== 1'b1 || s8_out_sum !== 8'h00 || s8_out_len !== 5'd2 || s8_out_ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_wrap got valid=%b sum=%0h len=%0d ovf=%b required 1 0 2 1",
               s8_out_valid, s8_out_sum, s8_out_len, s8_out_ovf);
    end
    @(negedge clk);
    s8_in_valid = 1'b1;
    s8_in_data  = 8'h01;
    s8_in_last  = 1'b1;
    @(negedge clk);
    s8_in_valid = 1'b0;
    s8_in_last  = 1'b0;
    checks++;
    if (s8_out_valid !== 1'b1 || s8_out_sum !== 8'h01 || s8_out_len !== 5'd1 || s8_out_ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_clear got valid=%b sum=%0h len=%0d ovf=%b required 1 1 1 0",
               s8_out_valid, s8_out_sum, s8_out_len, s8_out_ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    pulses       = 0;
    stalls       = 0;
    rst          = 1'b0;
    in_data      = 8'd0;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    out_ready    = 1'b0;
    s8_in_data   = 8'd0;
    s8_in_valid  = 1'b0;
    s8_in_last   = 1'b0;
    s8_out_ready = 1'b0;
    @(negedge clk);
    test_reset;
    test_full_frame;
    test_back_to_back;
    test_early_last;
    test_backpressure;
    test_reset_mid_frame;
    test_overflow;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
